// File: rtl/conv_mac_sequencer.sv
// Sequencer for one KxK convolution window: streams operands from the image/weight buffers and accumulates products through the shared ALU.
// Optional macro CONV_RELU_EN clamps negative window sums to zero when the result is loaded.
module conv_mac_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int MAX_K  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        k_size,
    input  logic [ADDR_W-1:0] img_base,
    input  logic [ADDR_W-1:0] img_stride,
    input  logic [ADDR_W-1:0] wgt_base,
    output logic [ADDR_W-1:0] img_addr,
    output logic [ADDR_W-1:0] wgt_addr,
    output logic              rd_en,
    input  logic [DATA_W-1:0] img_data,
    input  logic [DATA_W-1:0] wgt_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_overflow,
    output logic              busy,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              ovf,
    output logic              err
);

    localparam logic [2:0] K_MAX = 3'(MAX_K);
    localparam logic [2:0] ALU_ADD = 3'b000;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

    state_t state, state_nxt;

    logic [2:0]               k_lat;
    logic [2:0]               row;
    logic [2:0]               col;
    logic [ADDR_W-1:0]        stride_r;
    logic [ADDR_W-1:0]        img_row;
    logic signed [DATA_W-1:0] acc;
    logic                     vld_p1;
    logic                     accept;
    logic                     reject;
    logic                     k_ok;
    logic                     last_elem;
    logic                     acc_en;
    logic signed [DATA_W-1:0] product_p1;

    function automatic logic signed [DATA_W-1:0] mul_trunc(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        // Self-determined DATA_W context keeps only the low bits of the product.
        return a * b;
    endfunction

    function automatic logic [DATA_W-1:0] relu_out(input logic [DATA_W-1:0] v);
`ifdef CONV_RELU_EN
        return v[DATA_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    assign k_ok      = (k_size != 3'd0) && (k_size <= K_MAX);
    assign last_elem = (row == k_lat - 3'd1) && (col == k_lat - 3'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        reject    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (k_ok) begin
                        accept    = 1'b1;
                        state_nxt = FETCH;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (last_elem) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                if (result_valid && result_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Stage p1: buffer data for the element issued last cycle is on img_data/wgt_data.
    assign acc_en     = ((state == FETCH) && vld_p1) || (state == DRAIN);
    assign product_p1 = mul_trunc($signed(img_data), $signed(wgt_data));

    assign rd_en    = (state == FETCH);
    assign busy     = (state != IDLE);
    assign alu_ctrl = ALU_ADD;
    assign alu_a    = acc_en ? acc : '0;
    assign alu_b    = acc_en ? product_p1 : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            k_lat        <= '0;
            row          <= '0;
            col          <= '0;
            stride_r     <= '0;
            img_row      <= '0;
            img_addr     <= '0;
            wgt_addr     <= '0;
            acc          <= '0;
            vld_p1       <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            ovf          <= 1'b0;
            err          <= 1'b0;
        end else begin
            vld_p1 <= (state == FETCH);
            err    <= reject;

            if (accept) begin
                k_lat    <= k_size;
                stride_r <= img_stride;
                row      <= '0;
                col      <= '0;
                img_row  <= img_base;
                img_addr <= img_base;
                wgt_addr <= wgt_base;
                acc      <= '0;
                ovf      <= 1'b0;
            end

            // Addresses are walked incrementally; wrap at 2^ADDR_W is intended.
            if (state == FETCH) begin
                wgt_addr <= wgt_addr + 1'b1;
                if (col == k_lat - 3'd1) begin
                    col      <= '0;
                    row      <= row + 3'd1;
                    img_row  <= img_row + stride_r;
                    img_addr <= img_row + stride_r;
                end else begin
                    col      <= col + 3'd1;
                    img_addr <= img_addr + 1'b1;
                end
            end

            if (acc_en) begin
                acc <= $signed(alu_result);
                ovf <= ovf | alu_overflow;
            end

            if (state == DRAIN) begin
                result       <= relu_out(alu_result);
                result_valid <= 1'b1;
            end

            if ((state == HOLD) && result_ready) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Self-checking bench for conv_mac_sequencer: buffer and ALU models, scoreboard queues for addresses and window results.
module tb_conv_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  k_size = 3'd0;
    logic [9:0]  img_base = '0;
    logic [9:0]  img_stride = '0;
    logic [9:0]  wgt_base = '0;
    logic [9:0]  img_addr;
    logic [9:0]  wgt_addr;
    logic        rd_en;
    logic [31:0] img_data = '0;
    logic [31:0] wgt_data = '0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_overflow;
    logic        busy;
    logic [31:0] result;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic        ovf;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] img_mem [1024];
    logic [31:0] wgt_mem [1024];

    logic [9:0]  exp_img_q [$];
    logic [9:0]  exp_wgt_q [$];
    logic [31:0] exp_res_q [$];
    logic        exp_ovf_q [$];

    conv_mac_sequencer #(.DATA_W(32), .ADDR_W(10), .MAX_K(5)) dut (
        .clk(clk), .rst(rst), .start(start), .k_size(k_size),
        .img_base(img_base), .img_stride(img_stride), .wgt_base(wgt_base),
        .img_addr(img_addr), .wgt_addr(wgt_addr), .rd_en(rd_en),
        .img_data(img_data), .wgt_data(wgt_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .busy(busy), .result(result), .result_valid(result_valid),
        .result_ready(result_ready), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) begin
            img_data <= img_mem[img_addr];
            wgt_data <= wgt_mem[wgt_addr];
        end
    end

    assign alu_result   = alu_a + alu_b;
    assign alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_mems();
        for (int i = 0; i < 1024; i++) begin
            img_mem[i] = '0;
            wgt_mem[i] = '0;
        end
    endtask

    task automatic expect_window(input int k, input logic [9:0] ib, input logic [9:0] st,
                                 input logic [9:0] wb);
        logic [31:0] s;
        logic [31:0] p;
        logic [31:0] n;
        logic        o;
        logic [9:0]  ia;
        logic [9:0]  wa;
        s = '0;
        o = 1'b0;
        for (int r = 0; r < k; r++) begin
            for (int c = 0; c < k; c++) begin
                ia = ib + 10'(r) * st + 10'(c);
                wa = wb + 10'(r * k + c);
                exp_img_q.push_back(ia);
                exp_wgt_q.push_back(wa);
                p = img_mem[ia] * wgt_mem[wa];
                n = s + p;
                if ((s[31] == p[31]) && (n[31] != s[31])) o = 1'b1;
                s = n;
            end
        end
`ifdef CONV_RELU_EN
        if (s[31]) s = '0;
`endif
        exp_res_q.push_back(s);
        exp_ovf_q.push_back(o);
    endtask

    task automatic run_window(input int k, input logic [9:0] ib, input logic [9:0] st,
                              input logic [9:0] wb, input int hold, input bit poke_start);
        int          cyc;
        bit          done;
        logic [31:0] held;
        expect_window(k, ib, st, wb);
        @(negedge clk);
        start = 1'b1; k_size = 3'(k); img_base = ib; img_stride = st; wgt_base = wb;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        done = 1'b0;
        check("busy_after_accept", 32'(busy), 1);
        while (!done && cyc <= 40) begin
            check("alu_ctrl", 32'(alu_ctrl), 0);
            if (rd_en) begin
                if (exp_img_q.size() == 0) begin
                    check("extra_read", 32'(rd_en), 0);
                end else begin
                    check("img_addr", 32'(img_addr), 32'(exp_img_q.pop_front()));
                    check("wgt_addr", 32'(wgt_addr), 32'(exp_wgt_q.pop_front()));
                end
            end
            if (result_valid) begin
                done = 1'b1;
                check("latency", cyc, k * k + 1);
                check("result", result, exp_res_q.pop_front());
                check("ovf", 32'(ovf), 32'(exp_ovf_q.pop_front()));
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!done) check("result_valid_timeout", 0, 1);
        check("reads_issued", exp_img_q.size(), 0);
        exp_img_q.delete();
        exp_wgt_q.delete();
        held = result;
        for (int i = 0; i < hold; i++) begin
            start = poke_start && (i == 1);
            k_size = 3'd1;
            @(negedge clk);
            check("hold_result", result, held);
            check("hold_valid", 32'(result_valid), 1);
            check("hold_busy", 32'(busy), 1);
            check("hold_err", 32'(err), 0);
            check("hold_rd_en", 32'(rd_en), 0);
        end
        start = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check("handshake_valid", 32'(result_valid), 0);
        check("handshake_busy", 32'(busy), 0);
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);
        check("idle_err", 32'(err), 0);
    endtask

    task automatic reject_k(input logic [2:0] k);
        @(negedge clk);
        start = 1'b1; k_size = k;
        @(negedge clk);
        start = 1'b0;
        check("err_pulse", 32'(err), 1);
        check("err_busy", 32'(busy), 0);
        @(negedge clk);
        check("err_cleared", 32'(err), 0);
        check("err_idle", 32'(busy), 0);
        check("err_no_read", 32'(rd_en), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_rd_en"}, 32'(rd_en), 0);
        check({tag, "_valid"}, 32'(result_valid), 0);
        check({tag, "_ovf"}, 32'(ovf), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_img_addr"}, 32'(img_addr), 0);
        check({tag, "_wgt_addr"}, 32'(wgt_addr), 0);
        check({tag, "_alu_a"}, alu_a, 0);
        check({tag, "_alu_b"}, alu_b, 0);
    endtask

    initial begin
        clear_mems();
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        // K=1 single product with a negative weight
        img_mem[5] = 32'd7;
        wgt_mem[0] = 32'hFFFF_FFFD;
        run_window(1, 10'd5, 10'd1, 10'd0, 0, 1'b0);

        reject_k(3'd0);
        reject_k(3'd6);

        // K=3, stride 8, all ones
        clear_mems();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                img_mem[r * 8 + c] = 32'd1;
                wgt_mem[r * 3 + c] = 32'd1;
            end
        end
        run_window(3, 10'd0, 10'd8, 10'd0, 0, 1'b0);

        // K=2, every product 0x7FFFFFFF; held 5 cycles with a start poked in HOLD
        for (int i = 0; i < 4; i++) wgt_mem[200 + i] = 32'd1;
        img_mem[100] = 32'h7FFF_FFFF;
        img_mem[101] = 32'h7FFF_FFFF;
        img_mem[110] = 32'h7FFF_FFFF;
        img_mem[111] = 32'h7FFF_FFFF;
        run_window(2, 10'd100, 10'd10, 10'd200, 5, 1'b1);

        // K=5 random signed data, then K=2 with both address streams wrapping
        for (int i = 0; i < 1024; i++) begin
            img_mem[i] = $urandom;
            wgt_mem[i] = 32'($signed($urandom_range(0, 200)) - 100);
        end
        run_window(5, 10'd300, 10'd20, 10'd400, 1, 1'b0);
        run_window(2, 10'd1020, 10'd3, 10'd1022, 0, 1'b0);

        // Abort a K=3 window mid-FETCH, then a K=1 request must be clean
        @(negedge clk);
        start = 1'b1; k_size = 3'd3; img_base = 10'd0; img_stride = 10'd8; wgt_base = 10'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_mid_fetch", 32'(rd_en), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("abort");
        rst = 1'b0;
        img_mem[5] = 32'd7;
        wgt_mem[0] = 32'hFFFF_FFFD;
        run_window(1, 10'd5, 10'd1, 10'd0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
